// File: rtl/seq_sched_pkg.sv
// Shared encodings and helpers for the shared 1101 detector scheduler.
package seq_sched_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FLUSH, DONE} ctrl_state_t;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_state_t;

  // Round-robin pointer step: the slot after the one just served.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/seq1101_detector.sv
// Moore 1101 detector; z is high for one cycle in S4, which always returns to S0.
module seq1101_detector
  import seq_sched_pkg::*;
(
  input  logic Clock,
  input  logic Resetn,
  input  logic clr,
  input  logic w,
  output logic z
);

  det_state_t state, next;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S0;
    else         state <= next;
  end

  always_comb begin
    next = S0;
    if (!clr) begin
      case (state)
        S0:      next = w ? S1 : S0;
        S1:      next = w ? S2 : S0;
        S2:      next = w ? S0 : S3;
        S3:      next = w ? S4 : S0;
        default: next = S0;
      endcase
    end
  end

  assign z = (state == S4);

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin front end that serialises one requester's word into the shared
// 1101 detector and returns the saturating match count with an ack pulse.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WORD_W-1:0]    data,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       result_valid,
  output logic [CNT_W-1:0]           match_count,
  output logic                       z_mon
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  ctrl_state_t       state, next;
  logic [ID_W-1:0]   ptr, sel, pick;
  logic [ID_W-1:0]   cand [N_REQ];
  logic              found;
  logic [WORD_W-1:0] words [N_REQ];
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              w, z, clr;

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = data[i*WORD_W +: WORD_W];
  end

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand[k] = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand[k]]) begin
        found = 1'b1;
        pick  = cand[k];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (found) next = LOAD;
      LOAD:    next = SHIFT;
      SHIFT:   if (bit_cnt == BC_W'(WORD_W-1)) next = FLUSH;
      FLUSH:   next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ptr         <= '0;
      sel         <= '0;
      grant_id    <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      match_count <= '0;
    end else begin
      case (state)
        IDLE:  if (found) sel <= pick;
        LOAD: begin
          grant_id <= sel;
          shreg    <= words[sel];
          bit_cnt  <= '0;
          cnt      <= '0;
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + BC_W'(1);
          if (z) cnt <= cnt_inc;
        end
        // A match finished on the last bit is only visible here.
        FLUSH: match_count <= z ? cnt_inc : cnt;
        DONE:  ptr <= ID_W'(rr_next(int'(grant_id), N_REQ));
        default: ;
      endcase
    end
  end

  assign clr = (state == LOAD);
  assign w   = (state == SHIFT) && shreg[WORD_W-1];

  seq1101_detector u_det (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (clr),
    .w      (w),
    .z      (z)
  );

  always_comb begin
    ack = '0;
    if (state == DONE) ack[grant_id] = 1'b1;
  end

  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign z_mon        = z;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench: drivers push expected (id, count), monitors pop on result_valid.
module tb_seq_detect_scheduler;

  typedef struct {int id; int cnt;} exp_t;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic [3:0]   req = '0;
  logic [63:0]  data = '0;
  logic [3:0]   ack;
  logic         busy, result_valid, z_mon;
  logic [1:0]   grant_id;
  logic [3:0]   match_count;

  logic [1:0]   req2 = '0;
  logic [127:0] data2 = '0;
  logic [1:0]   ack2;
  logic         busy2, rv2, z2;
  logic [0:0]   gid2;
  logic [1:0]   mc2;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t q2[$];

  always #5 Clock = ~Clock;

  seq_detect_scheduler dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .data(data), .ack(ack), .busy(busy),
    .grant_id(grant_id), .result_valid(result_valid), .match_count(match_count), .z_mon(z_mon)
  );

  seq_detect_scheduler #(.N_REQ(2), .WORD_W(64), .CNT_W(2)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .req(req2), .data(data2), .ack(ack2), .busy(busy2),
    .grant_id(gid2), .result_valid(rv2), .match_count(mc2), .z_mon(z2)
  );

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (result_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got id %0d expected none", grant_id);
      end else begin
        e = q.pop_front();
        check("grant_id", int'(grant_id), e.id);
        check("ack", int'(ack), 1 << e.id);
        check("match_count", int'(match_count), e.cnt);
      end
    end
    for (int i = 0; i < 4; i++) if (ack[i]) req[i] = 1'b0;
  end

  always @(negedge Clock) begin
    exp_t e;
    if (rv2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result2: got id %0d expected none", gid2);
      end else begin
        e = q2.pop_front();
        check("grant_id2", int'(gid2), e.id);
        check("ack2", int'(ack2), 1 << e.id);
        check("match_count2", int'(mc2), e.cnt);
      end
    end
    for (int i = 0; i < 2; i++) if (ack2[i]) req2[i] = 1'b0;
  end

  task automatic push(input int id, input int cnt);
    exp_t e;
    e.id = id; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || busy2 || req != 0 || req2 != 0 || q.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge Clock);
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL timeout: waited %0d cycles expected idle", n);
      req = '0; req2 = '0; q.delete(); q2.delete();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ack", int'(ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_match_count", int'(match_count), 0);
    check("rst_z_mon", int'(z_mon), 0);
  endtask

  task automatic do_reset();
    req = '0;
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic serve(input int id, input logic [15:0] word, input int cnt);
    data[id*16 +: 16] = word;
    push(id, cnt);
    req[id] = 1'b1;
    wait_idle(200);
  endtask

  initial begin
    int cyc;
    #1;
    check_reset_outputs();
    do_reset();

    // 1: latency from req to ack
    data[15:0] = 16'hD000;
    push(0, 1);
    req[0] = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge Clock);
      cyc++;
      @(negedge Clock);
      if (ack[0]) break;
    end
    check("latency", cyc, 19);
    wait_idle(200);

    // 2: two separated matches; data change during SHIFT ignored
    data[15:0] = 16'hD680;
    push(0, 2);
    req[0] = 1'b1;
    repeat (6) @(negedge Clock);
    data[15:0] = 16'h0000;
    wait_idle(200);

    // 3: no overlap, and a match completed on the last bit
    serve(1, 16'h00DD, 1);
    serve(1, 16'h000D, 1);

    // 5: no-match words
    serve(2, 16'hFFFF, 0);
    serve(3, 16'h0000, 0);

    // 4: round robin after reset, with req0 re-raised during service of 2
    do_reset();
    data[15:0]  = 16'hD000;
    data[47:32] = 16'hD680;
    push(0, 1);
    push(2, 2);
    req = 4'b0101;
    cyc = 0;
    while (!ack[0] && cyc < 100) begin
      @(negedge Clock);
      cyc++;
    end
    check("ack0_seen", int'(ack[0]), 1);
    repeat (5) @(negedge Clock);
    data[15:0] = 16'hD68D;
    push(0, 3);
    req[0] = 1'b1;
    wait_idle(300);

    // 6: async reset in SHIFT bit 7, then req3 alone gets a full recount
    data[15:0] = 16'hD680;
    req[0] = 1'b1;
    repeat (9) @(posedge Clock);
    #2;
    Resetn = 1'b0;
    req = '0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    serve(3, 16'hD680, 2);

    // saturation on the wide, narrow-counter instance
    begin
      exp_t e;
      data2[127:64] = {4{16'hD680}};
      e.id = 1; e.cnt = 3; q2.push_back(e);
      req2[1] = 1'b1;
      wait_idle(400);
      data2[63:0] = {16'hD680, 48'h0};
      e.id = 0; e.cnt = 2; q2.push_back(e);
      req2[0] = 1'b1;
      wait_idle(400);
    end

    check("queue_empty", q.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
